// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: blank pattern, digit
// control bundle and the active-low nibble decoder.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
    logic       lzb;
    logic       blink_off;
    logic       pwm_off;
  } digit_ctl_t;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] nib,
    input logic       hex_mode
  );
    logic [6:0] r;
    r = SEG_BLANK;
    case (nib)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h58;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
    endcase
    if (!hex_mode && nib > 4'd9)
      r = SEG_BLANK;
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_digit.sv
// One digit: decode plus blank, blink and PWM gating.
// Any gating reason turns segments and dp off.
module sevenseg_digit
  import sevenseg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  digit_ctl_t ctl,
  output logic [6:0] seg,
  output logic       dp_n
);

  logic hi;
  logic blank;

  assign hi    = ctl.code > 4'd9;
  assign blank = ctl.lzb | (hi & (HEX_MODE == 0));

  // blank beats blink beats PWM; all force everything off
  always_comb begin
    seg  = seg_decode(ctl.code, HEX_MODE != 0);
    dp_n = ~ctl.dp;
    if (blank | ctl.blink_off | ctl.pwm_off) begin
      seg  = SEG_BLANK;
      dp_n = 1'b1;
    end
  end

endmodule

// File: rtl/sevenseg_display_ctrl.sv
// Registered N-digit 7-segment driver with hex mode,
// leading-zero blanking, per-digit blink and PWM dimming.
module sevenseg_display_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int HEX_MODE   = 0,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [NUM_DIGITS-1:0]   dp_n
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    run_q;
  logic [BW-1:0]           bcnt;
  logic                    phase;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic                    pwm_off;
  logic [7*NUM_DIGITS-1:0] seg_w;
  logic [NUM_DIGITS-1:0]   dpn_w;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0]   dpn_q;

  // capture registers; run_q keeps the first edge blank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
      blink_q <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
        blink_q <= blink_en;
      end
    end
  end

  // free-running blink divider, phase flips on wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  // free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  assign pwm_off = pwm_cnt >= brightness;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    digit_ctl_t ctl;
    logic       lzb;

    if (i == 0) begin : g_lsd
      assign lzb = 1'b0;
    end else begin : g_hi
      assign lzb = lz_blank &
                   ~|value_q[4*NUM_DIGITS-1:4*i];
    end

    assign ctl.code      = value_q[4*i +: 4];
    assign ctl.dp        = dp_q[i];
    assign ctl.lzb       = lzb;
    assign ctl.blink_off = phase & blink_q[i];
    assign ctl.pwm_off   = pwm_off;

    sevenseg_digit #(
      .HEX_MODE (HEX_MODE)
    ) u_dig (
      .ctl  (ctl),
      .seg  (seg_w[7*i +: 7]),
      .dp_n (dpn_w[i])
    );
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= '1;
      dpn_q <= '1;
    end else if (!run_q) begin
      hex_q <= '1;
      dpn_q <= '1;
    end else begin
      hex_q <= seg_w;
      dpn_q <= dpn_w;
    end
  end

  assign hex  = hex_q;
  assign dp_n = dpn_q;

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
// Bench for sevenseg_display_ctrl: two instances (plain
// and hex mode) against a cycle-count reference model.
module tb_sevenseg_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam int PP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [23:0]   value = '0;
  logic [5:0]    dp_in = '0;
  logic [5:0]    blink_en = '0;
  logic          lz_blank = 1'b0;
  logic [1:0]    brightness = 2'd3;
  logic [41:0]   hex0, hex1;
  logic [5:0]    dpn0, dpn1;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [23:0] mv, pv;
  logic [5:0]  md, pd, mb, pb;

  string tbl [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
    "acdefg", "abcf", "abcdefg", "abcdfg", "abcefg",
    "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  sevenseg_display_ctrl #(
    .NUM_DIGITS (ND), .HEX_MODE (0),
    .BLINK_DIV (BD), .PWM_BITS (2)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .load (load),
    .value (value), .dp_in (dp_in),
    .blink_en (blink_en), .lz_blank (lz_blank),
    .brightness (brightness), .hex (hex0),
    .dp_n (dpn0)
  );

  sevenseg_display_ctrl #(
    .NUM_DIGITS (ND), .HEX_MODE (1),
    .BLINK_DIV (BD), .PWM_BITS (2)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .load (load),
    .value (value), .dp_in (dp_in),
    .blink_en (blink_en), .lz_blank (lz_blank),
    .brightness (brightness), .hex (hex1),
    .dp_n (dpn1)
  );

  // model state: n = edges since release, pv = data
  // the output register saw at edge n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; mv = '0; md = '0; mb = '0;
      pv = '0; pd = '0; pb = '0;
    end else begin
      n++;
      pv = mv; pd = md; pb = mb;
      if (load) begin
        mv = value; md = dp_in; mb = blink_en;
      end
    end
  end

  function automatic logic [6:0] lit_mask(int c);
    logic [6:0] m;
    string s;
    m = '0;
    s = tbl[c];
    for (int j = 0; j < s.len(); j++)
      m[s[j] - 8'h61] = 1'b1;
    return m;
  endfunction

  function automatic bit is_lit();
    return ((n - 1) % PP) < int'(brightness);
  endfunction

  function automatic logic [47:0] model(bit hm);
    logic [47:0] r;
    int          c, ph, pw;
    logic [3:0]  code;
    bit          off, hz;
    r = '1;
    if (n < 2) return r;
    c  = n - 1;
    ph = (c / BD) % 2;
    pw = c % PP;
    for (int i = 0; i < ND; i++) begin
      code = pv[4*i +: 4];
      hz   = (pv >> (4 * i)) == 24'd0;
      off  = (lz_blank && i != 0 && hz) ||
             (!hm && code > 9) ||
             (pb[i] && ph == 1) ||
             (pw >= int'(brightness));
      r[6 + 7*i +: 7] = off ? 7'h7F : ~lit_mask(code);
      r[i]            = off ? 1'b1 : ~pd[i];
    end
    return r;
  endfunction

  task automatic do_load(
    input logic [23:0] v, input logic [5:0] d,
    input logic [5:0] b
  );
    load = 1'b1; value = v; dp_in = d; blink_en = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hex0, dpn0, hex1, dpn1} !== '1) begin
      errors++;
      $display("FAIL reset_hold got %h %h exp all ones",
               hex0, hex1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({hex0, dpn0, hex1, dpn1} !== '1) begin
      errors++;
      $display("FAIL reset_first_edge got %h %h exp ones",
               hex0, hex1);
    end
  endtask

  task automatic test_decode();
    bit done;
    lz_blank = 1'b0; brightness = 2'd3;
    do_load(24'h012345, 6'b101010, 6'b0);
    done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({hex0, dpn0} !== model(0) ||
          {hex1, dpn1} !== model(1)) begin
        errors++;
        $display("FAIL decode n=%0d got %h/%h exp %h/%h",
                 n, {hex0, dpn0}, {hex1, dpn1},
                 model(0), model(1));
      end
      if (!done && is_lit()) begin
        done = 1;
        checks++;
        if (hex0 !== {7'h40, 7'h79, 7'h24, 7'h30,
                      7'h19, 7'h12}) begin
          errors++;
          $display("FAIL decode_012345 got %h", hex0);
        end
      end
    end
    do_load(24'h00000A, 6'b0, 6'b0);
    done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!done && is_lit()) begin
        done = 1;
        checks++;
        if (hex0[6:0] !== 7'h7F || hex1[6:0] !== 7'h08)
        begin
          errors++;
          $display("FAIL decode_A got %h/%h exp 7f/08",
                   hex0[6:0], hex1[6:0]);
        end
      end
    end
  endtask

  task automatic test_hexmode();
    bit done;
    do_load(24'hABCDEF, 6'b0, 6'b0);
    done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({hex1, dpn1} !== model(1) ||
          {hex0, dpn0} !== model(0)) begin
        errors++;
        $display("FAIL hexmode n=%0d got %h exp %h",
                 n, {hex1, dpn1}, model(1));
      end
      if (!done && is_lit()) begin
        done = 1;
        checks++;
        if (hex1 !== {7'h08, 7'h03, 7'h46, 7'h21,
                      7'h06, 7'h0E} || hex0 !== '1) begin
          errors++;
          $display("FAIL hex_ABCDEF got %h/%h", hex1, hex0);
        end
      end
    end
  endtask

  task automatic test_lz();
    bit done;
    lz_blank = 1'b1;
    do_load(24'h000120, 6'b111111, 6'b0);
    done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({hex0, dpn0} !== model(0)) begin
        errors++;
        $display("FAIL lz_120 n=%0d got %h exp %h",
                 n, {hex0, dpn0}, model(0));
      end
      if (!done && is_lit()) begin
        done = 1;
        checks++;
        if ({hex0, dpn0} !== {7'h7F, 7'h7F, 7'h7F, 7'h79,
                              7'h24, 7'h40, 6'b111000})
        begin
          errors++;
          $display("FAIL lz_120_lit got %h/%b",
                   hex0, dpn0);
        end
      end
    end
    do_load(24'h000000, 6'b0, 6'b0);
    done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!done && is_lit()) begin
        done = 1;
        checks++;
        if (hex0 !== {{5{7'h7F}}, 7'h40}) begin
          errors++;
          $display("FAIL lz_zero got %h", hex0);
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_blink();
    brightness = 2'd3;
    do_load(24'h000008, 6'b0, 6'b000001);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({hex0, dpn0} !== model(0) ||
          {hex1, dpn1} !== model(1)) begin
        errors++;
        $display("FAIL blink n=%0d got %h exp %h",
                 n, {hex0, dpn0}, model(0));
      end
    end
  endtask

  task automatic test_pwm();
    int on;
    brightness = 2'd1;
    do_load(24'h888888, 6'b0, 6'b0);
    on = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (hex0[6:0] == 7'h00) on++;
      checks++;
      if ({hex0, dpn0} !== model(0)) begin
        errors++;
        $display("FAIL pwm1 n=%0d got %h exp %h",
                 n, {hex0, dpn0}, model(0));
      end
    end
    checks++;
    if (on != 3) begin
      errors++;
      $display("FAIL pwm1_duty got %0d of 12 exp 3", on);
    end
    brightness = 2'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (hex0 !== '1 || dpn0 !== '1) begin
        errors++;
        $display("FAIL pwm0 got %h exp all ones", hex0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      load     = ($urandom_range(0, 2) == 0);
      value    = 24'($urandom);
      if ($urandom_range(0, 1) == 1)
        value = value & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
      dp_in    = 6'($urandom);
      blink_en = 6'($urandom);
      if ($urandom_range(0, 7) == 0)
        lz_blank = ~lz_blank;
      if ($urandom_range(0, 7) == 0)
        brightness = 2'($urandom);
      @(negedge clk);
      checks++;
      if ({hex0, dpn0} !== model(0) ||
          {hex1, dpn1} !== model(1)) begin
        errors++;
        $display("FAIL random n=%0d got %h/%h exp %h/%h",
                 n, {hex0, dpn0}, {hex1, dpn1},
                 model(0), model(1));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_midreset();
    brightness = 2'd3;
    lz_blank = 1'b0;
    do_load(24'h123456, 6'b111111, 6'b0);
    repeat (2) @(negedge clk);
    load = 1'b1; value = 24'h987654;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hex0, dpn0, hex1, dpn1} !== '1) begin
      errors++;
      $display("FAIL midreset got %h/%h exp ones",
               hex0, hex1);
    end
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({hex0, dpn0} !== model(0) ||
          {hex1, dpn1} !== model(1)) begin
        errors++;
        $display("FAIL after_reset n=%0d got %h exp %h",
                 n, {hex0, dpn0}, model(0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_hexmode();
    test_lz();
    test_blink();
    test_pwm();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
